// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end with credit-limited memory
// requests and an in-order instruction/PC FIFO feeding decode.
module fetch_queue #(
    parameter int          XLEN       = 32,
    parameter int          ADDR_WIDTH = 10,
    parameter int          DEPTH      = 4,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  redirect,
    input  logic [XLEN-1:0]       redirect_pc,
    output logic                  imem_req_valid,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_rsp_valid,
    input  logic [XLEN-1:0]       imem_rsp_data,
    output logic                  out_valid,
    output logic [XLEN-1:0]       out_instr,
    output logic [XLEN-1:0]       out_pc,
    output logic [XLEN-1:0]       out_pcplus4,
    input  logic                  out_ready
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         outst_q, outst_d;
    logic [CW-1:0]         drop_q, drop_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  boot_q, boot_d;

    logic [XLEN-1:0]       instr_mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem_q [DEPTH];

    logic [CW:0] credit;
    logic        accept;
    logic        drop_hit;
    logic        push;
    logic        pop;
    logic        unused_pc_hi;

    assign unused_pc_hi = ^redirect_pc[XLEN-1:ADDR_WIDTH];

    // In-flight requests plus buffered entries never exceed DEPTH,
    // so every response always has a free FIFO slot.
    assign credit = {1'b0, outst_q} + {1'b0, cnt_q};

    assign imem_req_valid = ~reset & ~boot_q & ~redirect
                          & (credit < (CW + 1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;

    assign out_valid   = ~reset & ~boot_q & ~redirect & (cnt_q != '0);
    assign out_instr   = instr_mem_q[rd_ptr_q];
    assign out_pc      = XLEN'(pc_mem_q[rd_ptr_q]);
    assign out_pcplus4 = out_pc + XLEN'(1);

    assign accept   = imem_req_valid & imem_req_ready;
    assign drop_hit = imem_rsp_valid & (drop_q != '0);
    assign push     = imem_rsp_valid & ~drop_hit;
    assign pop      = out_valid & out_ready;

    always_comb begin
        boot_d     = 1'b0;
        outst_d    = outst_q + CW'(accept) - CW'(imem_rsp_valid);
        fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(accept);
        rsp_pc_d   = rsp_pc_q + ADDR_WIDTH'(push);
        drop_d     = drop_q - CW'(drop_hit);
        cnt_d      = cnt_q + CW'(push) - CW'(pop);
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        if (redirect) begin
            // Everything still in flight after this cycle is wrong-path.
            fetch_pc_d = redirect_pc[ADDR_WIDTH-1:0];
            rsp_pc_d   = redirect_pc[ADDR_WIDTH-1:0];
            drop_d     = outst_d;
            cnt_d      = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= ADDR_WIDTH'(RESET_PC);
            rsp_pc_q   <= ADDR_WIDTH'(RESET_PC);
            cnt_q      <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            boot_q     <= 1'b1;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            cnt_q      <= cnt_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            boot_q     <= boot_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push & ~redirect & ~reset) begin
            instr_mem_q[wr_ptr_q] <= imem_rsp_data;
            pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
        end
    end

    rsp_credit_a: assert property (
        @(posedge clk) disable iff (reset)
        imem_rsp_valid |-> (outst_q != '0)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench with an in-order variable-latency
// memory model and an expected-PC stream checked at the decode side.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [9:0]  imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pcplus4;
    logic        out_ready;

    int total = 0;
    int bad   = 0;
    int cyc;
    int lat;
    int acc_cnt;
    int first_cyc;
    bit tog;

    logic [9:0]  pend_a[$];
    int          pend_t[$];
    logic [31:0] exp_pc[$];

    always #5 clk = ~clk;

    fetch_queue dut (
        .clk            (clk),
        .reset          (reset),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pcplus4    (out_pcplus4),
        .out_ready      (out_ready)
    );

    function automatic logic [31:0] memf(logic [9:0] a);
        return {16'hC0DE, 6'h0, a} ^ 32'h0055_0000;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle; entered and left at posedge+1.
    task automatic step();
        logic [31:0] e;
        if (tog) imem_req_ready = cyc[0];
        if (pend_a.size() > 0 && pend_t[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memf(pend_a[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        @(negedge clk);
        if (redirect) begin
            check("redir_outv", {31'h0, out_valid}, 32'h0);
            check("redir_reqv", {31'h0, imem_req_valid}, 32'h0);
        end
        if (imem_req_valid && imem_req_ready) begin
            pend_a.push_back(imem_req_addr);
            pend_t.push_back(cyc + lat);
            acc_cnt++;
        end
        if (imem_rsp_valid) begin
            pend_a.delete(0);
            pend_t.delete(0);
        end
        if (out_valid && out_ready) begin
            if (first_cyc < 0) first_cyc = cyc;
            if (exp_pc.size() == 0) begin
                check("spurious_pc", out_pc, 32'hFFFF_FFFF);
            end else begin
                e = exp_pc.pop_front();
                check("out_pc", out_pc, e);
                check("out_instr", out_instr, memf(e[9:0]));
                check("out_pcplus4", out_pcplus4, e + 32'd1);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        tog            = 1'b0;
        pend_a.delete();
        pend_t.delete();
        exp_pc.delete();
        acc_cnt   = 0;
        first_cyc = -1;
        @(negedge clk);
        check("rst_reqv", {31'h0, imem_req_valid}, 32'h0);
        check("rst_outv", {31'h0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("boot_reqv", {31'h0, imem_req_valid}, 32'h0);
        check("boot_outv", {31'h0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
        cyc = 1;
    endtask

    task automatic drain(string tag, int bound);
        int n = 0;
        while (exp_pc.size() > 0 && n < bound) begin
            step();
            n++;
        end
        check(tag, exp_pc.size(), 0);
        out_ready = 1'b0;
    endtask

    task automatic fill(logic [31:0] base, int n);
        for (int i = 0; i < n; i++) exp_pc.push_back(base + i);
    endtask

    task automatic do_redirect(logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        step();
        redirect    = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        out_ready      = 1'b0;
        cyc            = 0;
        lat            = 1;
        @(posedge clk);
        #1;

        // Streaming, latency 1
        do_reset();
        lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
        check("t1_addr0", {22'h0, imem_req_addr}, 32'h0);
        fill(32'h0, 8);
        drain("t1_drain", 40);
        check("t1_first", first_cyc, 3);

        // Back-pressure fills the FIFO, then drains in order
        do_reset();
        lat = 2; imem_req_ready = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("t2_reqs", acc_cnt, 4);
        check("t2_full_reqv", {31'h0, imem_req_valid}, 32'h0);
        check("t2_outv", {31'h0, out_valid}, 32'h1);
        check("t2_head", out_pc, 32'h0);
        out_ready = 1'b1;
        fill(32'h0, 8);
        drain("t2_drain", 40);

        // Redirect with two stale requests in flight
        do_reset();
        lat = 3; imem_req_ready = 1'b1; out_ready = 1'b1;
        step();
        step();
        do_redirect(32'h0000_0040);
        fill(32'h40, 3);
        drain("t3_drain", 40);
        check("t3_first", first_cyc, 8);

        // Response lands in the redirect cycle with a non-empty FIFO
        do_reset();
        lat = 3; imem_req_ready = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("t4_pre_outv", {31'h0, out_valid}, 32'h1);
        do_redirect(32'h0000_0080);
        out_ready = 1'b1;
        fill(32'h80, 2);
        drain("t4_drain", 40);
        check("t4_first", first_cyc, 10);

        // Toggling memory ready
        do_reset();
        lat = 1; tog = 1'b1; out_ready = 1'b1;
        fill(32'h0, 6);
        drain("t5_drain", 60);
        tog = 1'b0;

        // Fetch address wraps at the top of the word space
        do_reset();
        lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
        do_redirect(32'h0000_13FF);
        check("t6_addr", {22'h0, imem_req_addr}, 32'h3FF);
        fill(32'h3FF, 1);
        fill(32'h0, 2);
        drain("t6_drain", 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
